// File: rtl/vending_ctrl_pkg.sv
// Shared definitions for the vending controller.
// Contents:
//   state_t       - 2-bit FSM state encoding (IDLE, COLLECT, VEND, REFUND)
//   DEF_*         - default coin values, price and stock
//   params_ok()   - elaboration-time legality check of the parameter set
package vending_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    REFUND  = 2'd3
  } state_t;

  localparam int DEF_CW    = 4;
  localparam int DEF_VAL_A = 1;
  localparam int DEF_VAL_B = 2;
  localparam int DEF_PRICE = 3;
  localparam int DEF_SW    = 3;
  localparam int DEF_STOCK = 2;

  // Worst-case credit is one unit short of the price plus both coins at once,
  // so the accumulator never needs overflow handling when this holds.
  function automatic bit params_ok(input int cw, input int val_a, input int val_b,
                                   input int price, input int sw, input int stock);
    return (price >= 1) &&
           (price + val_a + val_b - 1 <= (2 ** cw) - 1) &&
           (stock >= 0) && (stock <= (2 ** sw) - 1);
  endfunction

endpackage

// File: rtl/vending_ctrl_stock_cnt.sv
// Stock down-counter for the vending controller.
// Ports:
//   clk   in  rising-edge clock
//   rst   in  synchronous reset, active-low; loads STOCK
//   load  in  restock request; reloads STOCK, wins over dec
//   dec   in  one item vended
//   empty out registered flag, high when the stock level is zero
module vending_ctrl_stock_cnt #(
  parameter int SW    = 3,
  parameter int STOCK = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic empty
);

  logic [SW-1:0] stock_reg;
  logic [SW-1:0] stock_next;
  logic          empty_reg;

  always_comb begin
    stock_next = stock_reg;
    if (load) begin
      stock_next = SW'(STOCK);
    end else if (dec && (stock_reg != '0)) begin
      // Saturate at zero; a vend should never reach here with no stock.
      stock_next = stock_reg - SW'(1);
    end
  end

  // The flag is computed from the next value so it changes in the same
  // cycle the stock level does.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stock_reg <= SW'(STOCK);
      empty_reg <= (STOCK == 0);
    end else begin
      stock_reg <= stock_next;
      empty_reg <= (stock_next == '0);
    end
  end

  assign empty = empty_reg;

endmodule

// File: rtl/vending_ctrl.sv
// Coin-operated vending controller: accumulates credit from two coin inputs,
// vends once credit reaches PRICE, returns change, handles cancel/refund and
// blocks coins when the product is sold out.
// Ports:
//   clk      in   rising-edge clock
//   rst      in   synchronous reset, active-low
//   a, b     in   coin present (one coin per high cycle)
//   cancel   in   refund request
//   restock  in   reload stock to STOCK
//   credit   out  accumulated credit
//   out      out  vend pulse, one cycle
//   change   out  change/refund amount, valid with chg_vld, held otherwise
//   chg_vld  out  change strobe, one cycle
//   reject   out  coin(s) of this cycle returned, one-cycle pulse
//   empty    out  stock is zero
module vending_ctrl
  import vending_ctrl_pkg::*;
#(
  parameter int CW    = DEF_CW,
  parameter int VAL_A = DEF_VAL_A,
  parameter int VAL_B = DEF_VAL_B,
  parameter int PRICE = DEF_PRICE,
  parameter int SW    = DEF_SW,
  parameter int STOCK = DEF_STOCK
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          a,
  input  logic          b,
  input  logic          cancel,
  input  logic          restock,
  output logic [CW-1:0] credit,
  output logic          out,
  output logic [CW-1:0] change,
  output logic          chg_vld,
  output logic          reject,
  output logic          empty
);

  generate
    if (!params_ok(CW, VAL_A, VAL_B, PRICE, SW, STOCK)) begin : g_bad_params
      $error("vending_ctrl: illegal parameter set (credit width, price or stock)");
    end
  endgenerate

  state_t        state_reg, state_next;
  logic [CW-1:0] credit_reg, credit_next;
  logic [CW-1:0] change_reg, change_next;
  logic          out_reg, out_next;
  logic          chg_vld_reg, chg_vld_next;
  logic          reject_reg, reject_next;
  logic          vend_dec;
  logic [CW-1:0] coin_sum;

  vending_ctrl_stock_cnt #(
    .SW    (SW),
    .STOCK (STOCK)
  ) u_stock (
    .clk   (clk),
    .rst   (rst),
    .load  (restock),
    .dec   (vend_dec),
    .empty (empty)
  );

  assign coin_sum = credit_reg
                  + (a ? CW'(VAL_A) : '0)
                  + (b ? CW'(VAL_B) : '0);

  always_comb begin
    state_next   = state_reg;
    credit_next  = credit_reg;
    change_next  = change_reg;
    out_next     = 1'b0;
    chg_vld_next = 1'b0;
    reject_next  = 1'b0;
    vend_dec     = 1'b0;

    case (state_reg)
      IDLE, COLLECT: begin
        if (empty) begin
          reject_next = a | b;
        end else if (cancel && (credit_reg != '0)) begin
          state_next  = REFUND;
          reject_next = a | b;
        end else begin
          // A cancel with no credit falls through here and is ignored.
          credit_next = coin_sum;
          if (coin_sum >= CW'(PRICE)) begin
            state_next = VEND;
          end else if (coin_sum != '0) begin
            state_next = COLLECT;
          end else begin
            state_next = IDLE;
          end
        end
      end
      VEND: begin
        out_next     = 1'b1;
        chg_vld_next = 1'b1;
        change_next  = credit_reg - CW'(PRICE);
        credit_next  = '0;
        vend_dec     = 1'b1;
        reject_next  = a | b;
        state_next   = IDLE;
      end
      REFUND: begin
        chg_vld_next = 1'b1;
        change_next  = credit_reg;
        credit_next  = '0;
        reject_next  = a | b;
        state_next   = IDLE;
      end
      default: begin
        state_next  = IDLE;
        credit_next = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      credit_reg  <= '0;
      change_reg  <= '0;
      out_reg     <= 1'b0;
      chg_vld_reg <= 1'b0;
      reject_reg  <= 1'b0;
    end else begin
      state_reg   <= state_next;
      credit_reg  <= credit_next;
      change_reg  <= change_next;
      out_reg     <= out_next;
      chg_vld_reg <= chg_vld_next;
      reject_reg  <= reject_next;
    end
  end

  assign credit  = credit_reg;
  assign change  = change_reg;
  assign out     = out_reg;
  assign chg_vld = chg_vld_reg;
  assign reject  = reject_reg;

endmodule

// File: tb/tb_vending_ctrl.sv
`timescale 1ns/100ps
module tb_vending_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       a = 1'b0, b = 1'b0, cancel = 1'b0, restock = 1'b0;
  logic [3:0] credit, change;
  logic       out, chg_vld, reject, empty;

  typedef struct {
    logic       out;
    logic       chg;
    logic [3:0] change;
    logic       rej;
  } ev_t;

  ev_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  always #1 clk = ~clk;

  vending_ctrl dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .cancel  (cancel),
    .restock (restock),
    .credit  (credit),
    .out     (out),
    .change  (change),
    .chg_vld (chg_vld),
    .reject  (reject),
    .empty   (empty)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: any output event (vend, change strobe or reject) pops one
  // expected event from the scoreboard.
  always @(negedge clk) begin
    if (out | chg_vld | reject) begin
      ev_t e;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_event: out=%0b chg_vld=%0b change=%0d reject=%0b, none expected",
                 out, chg_vld, change, reject);
      end else begin
        e = exp_q.pop_front();
        $display("t=%0t event out=%0b chg_vld=%0b change=%0d reject=%0b", $time, out, chg_vld, change, reject);
        chk("ev_out", out, e.out);
        chk("ev_chg_vld", chg_vld, e.chg);
        chk("ev_reject", reject, e.rej);
        if (e.chg) chk("ev_change", change, e.change);
      end
    end
  end

  task automatic push(input logic o, input logic c, input logic [3:0] ch, input logic r);
    ev_t e;
    e.out = o; e.chg = c; e.change = ch; e.rej = r;
    exp_q.push_back(e);
  endtask

  // One clock: drive inputs, let the edge sample them, return just after the
  // following falling edge (monitor has already run).
  task automatic cyc(input logic ia, input logic ib, input logic ic, input logic ir);
    a = ia; b = ib; cancel = ic; restock = ir;
    @(negedge clk);
    #0.2;
    a = 1'b0; b = 1'b0; cancel = 1'b0; restock = 1'b0;
  endtask

  task automatic pending(input string name);
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    // Reset
    rst = 1'b0;
    cyc(0,0,0,0); cyc(0,0,0,0);
    chk("rst_credit", credit, 0);
    chk("rst_out", out, 0);
    chk("rst_chg_vld", chg_vld, 0);
    chk("rst_reject", reject, 0);
    chk("rst_change", change, 0);
    chk("rst_empty", empty, 0);
    rst = 1'b1;

    // 1: a, a, b -> credit 1,2,4 then vend with change 1
    cyc(1,0,0,0); chk("t1_credit1", credit, 1);
    cyc(1,0,0,0); chk("t1_credit2", credit, 2);
    push(1,1,4'd1,0);
    cyc(0,1,0,0); chk("t1_credit4", credit, 4);
    cyc(0,0,0,0); chk("t1_credit0", credit, 0);
    pending("t1_pending");
    chk("t1_empty", empty, 0);

    // 2: a+b together -> credit 3, vend change 0; second vend empties stock
    push(1,1,4'd0,0);
    cyc(1,1,0,0); chk("t2_credit3", credit, 3);
    cyc(0,0,0,0); chk("t2_credit0", credit, 0);
    pending("t2_pending");
    chk("t4_empty_after_two", empty, 1);

    // 4: sold out -> coin rejected, restock, then vend normally
    push(0,0,4'd0,1);
    cyc(1,0,0,0); chk("t4_credit_blocked", credit, 0);
    pending("t4_reject_pending");
    cyc(0,0,0,1); chk("t4_empty_restock", empty, 0);
    push(1,1,4'd0,0);
    cyc(1,1,0,0); chk("t4_credit3", credit, 3);
    cyc(0,0,0,0); chk("t4_credit0", credit, 0);
    pending("t4_vend_pending");
    chk("t4_empty_one_left", empty, 0);

    // 3: a then cancel -> refund 1
    cyc(1,0,0,0); chk("t3_credit1", credit, 1);
    push(0,1,4'd1,0);
    cyc(0,0,1,0); chk("t3_credit_refund", credit, 1);
    cyc(0,0,0,0); chk("t3_credit0", credit, 0);
    pending("t3_pending");
    // cancel+b at credit 1 -> b rejected, refund 1
    cyc(1,0,0,0);
    push(0,0,4'd0,1);
    cyc(0,1,1,0); chk("t3b_credit", credit, 1);
    pending("t3b_reject_pending");
    push(0,1,4'd1,0);
    cyc(0,0,0,0); chk("t3b_credit0", credit, 0);
    pending("t3b_refund_pending");
    // cancel with no credit is ignored
    cyc(0,0,1,0); chk("t3c_credit", credit, 0);
    pending("t3c_pending");

    // 6: coin during VEND cycle is rejected and not credited
    push(1,1,4'd0,1);
    cyc(1,1,0,0); chk("t6_credit3", credit, 3);
    cyc(1,0,0,0); chk("t6_credit0", credit, 0);
    pending("t6_pending");
    cyc(0,0,0,0); chk("t6_credit_after", credit, 0);
    pending("t6_no_extra");
    chk("t6_empty", empty, 1);

    // 5: reset mid-collect discards credit and reloads stock
    cyc(0,0,0,1); chk("t5_empty_restock", empty, 0);
    push(1,1,4'd0,0);
    cyc(1,0,0,0); cyc(1,0,0,0); cyc(1,0,0,0);
    chk("t5_credit3", credit, 3);
    cyc(0,0,0,0); pending("t5_vend_pending");
    cyc(0,1,0,0); chk("t5_credit2", credit, 2);
    rst = 1'b0;
    cyc(0,0,0,0);
    rst = 1'b1;
    chk("t5_credit_rst", credit, 0);
    chk("t5_out_rst", out, 0);
    chk("t5_chg_vld_rst", chg_vld, 0);
    chk("t5_reject_rst", reject, 0);
    chk("t5_change_rst", change, 0);
    pending("t5_no_refund");

    // Max credit: 2 + a + b = 5 -> change 2; stock reloaded to 2 by reset
    cyc(0,1,0,0); chk("max_credit2", credit, 2);
    push(1,1,4'd2,0);
    cyc(1,1,0,0); chk("max_credit5", credit, 5);
    cyc(0,0,0,0); chk("max_credit0", credit, 0);
    pending("max_pending");
    chk("t5_stock_reloaded", empty, 0);
    push(1,1,4'd0,0);
    cyc(1,1,0,0); cyc(0,0,0,0);
    pending("t5_last_pending");
    chk("t5_empty_final", empty, 1);

    cyc(0,0,0,0);
    pending("final_pending");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
